// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART command bytes into pipeline run/step/reset
// control and streams a five-word snapshot of the pipeline debug outputs back as bytes.
module debug_unit #(
  parameter int                    ADDR_BITS  = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [7:0]            CMD_RUN    = 8'h63,
  parameter logic [7:0]            CMD_STEP   = 8'h73,
  parameter logic [7:0]            CMD_RESET  = 8'h72,
  parameter logic [7:0]            CMD_DUMP   = 8'h64,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic                  pc_enable_out,
  output logic                  pc_reset_out,
  input  logic [ADDR_BITS-1:0]  pc_addr_in,
  input  logic [DATA_WIDTH-1:0] pc_instr_in,
  input  logic [DATA_WIDTH-1:0] reg_w_data_in,
  input  logic [DATA_WIDTH-1:0] reg_rt_data_in,
  input  logic [DATA_WIDTH-1:0] reg_rs_data_in,
  output logic                  running_out,
  output logic                  halted_out
);

  localparam int FRAME_W   = ADDR_BITS + 4 * DATA_WIDTH;
  localparam int NUM_BYTES = FRAME_W / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_PC_RST,
    S_IDLE,
    S_RUN,
    S_STEP,
    S_SNAP,
    S_SEND,
    S_WAIT_TX
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_BITS-1:0]    snap_pc_q, snap_pc_d;
  logic [DATA_WIDTH-1:0]   snap_instr_q, snap_instr_d;
  logic [DATA_WIDTH-1:0]   snap_w_q, snap_w_d;
  logic [DATA_WIDTH-1:0]   snap_rt_q, snap_rt_d;
  logic [DATA_WIDTH-1:0]   snap_rs_q, snap_rs_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    pc_enable_q, pc_enable_d;
  logic                    pc_reset_q, pc_reset_d;
  logic                    running_q, running_d;
  logic                    halted_q, halted_d;

  logic                    halt_hit;
  logic [FRAME_W-1:0]      frame_d;
  logic [FRAME_W-1:0]      frame_shift;

  assign halt_hit = (pc_instr_in == HALT_INSTR);

  // Word 0 sits in the low bits so byte n of the stream is simply frame[8n +: 8].
  assign frame_d     = {snap_rs_d, snap_rt_d, snap_w_d, snap_instr_d, snap_pc_d};
  assign frame_shift = frame_d >> {idx_d, 3'b000};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    snap_pc_d    = snap_pc_q;
    snap_instr_d = snap_instr_q;
    snap_w_d     = snap_w_q;
    snap_rt_d    = snap_rt_q;
    snap_rs_d    = snap_rs_q;
    halted_d     = halted_q;

    unique case (state_q)
      S_PC_RST: state_d = S_IDLE;

      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_RUN && !halted_q)       state_d = S_RUN;
          else if (rx_data == CMD_STEP && !halted_q) state_d = S_STEP;
          else if (rx_data == CMD_RESET)             state_d = S_PC_RST;
          else if (rx_data == CMD_DUMP)              state_d = S_SNAP;
        end
      end

      S_RUN: begin
        // Halt wins over a reset command arriving in the same cycle.
        if (halt_hit) begin
          halted_d = 1'b1;
          state_d  = S_SNAP;
        end else if (rx_valid && rx_data == CMD_RESET) begin
          state_d = S_PC_RST;
        end
      end

      S_STEP: begin
        if (halt_hit) halted_d = 1'b1;
        state_d = S_SNAP;
      end

      S_SNAP: begin
        snap_pc_d    = pc_addr_in;
        snap_instr_d = pc_instr_in;
        snap_w_d     = reg_w_data_in;
        snap_rt_d    = reg_rt_data_in;
        snap_rs_d    = reg_rs_data_in;
        idx_d        = '0;
        state_d      = S_SEND;
      end

      S_SEND: state_d = S_WAIT_TX;

      S_WAIT_TX: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end
        end
      end

      default: state_d = S_PC_RST;
    endcase

    if (state_d == S_PC_RST) halted_d = 1'b0;

    // Outputs are derived from the next state so they are registered yet line up with it.
    pc_reset_d  = (state_d == S_PC_RST);
    pc_enable_d = (state_d == S_RUN) || (state_d == S_STEP);
    running_d   = (state_d == S_RUN);
    tx_start_d  = (state_d == S_SEND);
    tx_data_d   = (state_d == S_SEND) ? frame_shift[7:0] : tx_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_PC_RST;
      idx_q        <= '0;
      // NOTE: the snapshot words are plain flops, so resetting them is cheap and
      // guarantees a dump before any capture returns zeros rather than X.
      snap_pc_q    <= '0;
      snap_instr_q <= '0;
      snap_w_q     <= '0;
      snap_rt_q    <= '0;
      snap_rs_q    <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      pc_enable_q  <= 1'b0;
      pc_reset_q   <= 1'b1;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_pc_q    <= snap_pc_d;
      snap_instr_q <= snap_instr_d;
      snap_w_q     <= snap_w_d;
      snap_rt_q    <= snap_rt_d;
      snap_rs_q    <= snap_rs_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      pc_enable_q  <= pc_enable_d;
      pc_reset_q   <= pc_reset_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign pc_enable_out = pc_enable_q;
  assign pc_reset_out  = pc_reset_q;
  assign running_out   = running_q;
  assign halted_out    = halted_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: reset, step+dump, run-to-halt, reset command,
// dropped input during a transfer and asynchronous reset mid-dump / mid-run.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        pc_enable_out;
  logic        pc_reset_out;
  logic [31:0] pc_addr_in = 32'h0;
  logic [31:0] pc_instr_in = 32'h0;
  logic [31:0] reg_w_data_in = 32'h0;
  logic [31:0] reg_rt_data_in = 32'h0;
  logic [31:0] reg_rs_data_in = 32'h0;
  logic        running_out;
  logic        halted_out;

  int n_pass = 0;
  int n_total = 0;
  int proto_err;
  int both_high = 0;
  logic [7:0] got [20];

  // Hand-computed byte streams for the two snapshots used below.
  logic [7:0] exp_a [20] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h20,
                             8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] exp_h [20] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                             8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};

  debug_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx_done        (tx_done),
    .pc_enable_out  (pc_enable_out),
    .pc_reset_out   (pc_reset_out),
    .pc_addr_in     (pc_addr_in),
    .pc_instr_in    (pc_instr_in),
    .reg_w_data_in  (reg_w_data_in),
    .reg_rt_data_in (reg_rt_data_in),
    .reg_rs_data_in (reg_rs_data_in),
    .running_out    (running_out),
    .halted_out     (halted_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pc_reset_out === 1'b1 && pc_enable_out === 1'b1) both_high++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic set_pipe_a();
    pc_addr_in     = 32'h0000_0004;
    pc_instr_in    = 32'h2001_0005;
    reg_w_data_in  = 32'h1122_3344;
    reg_rt_data_in = 32'hA5A5_0F0F;
    reg_rs_data_in = 32'hDEAD_BEEF;
  endtask

  // Transmitter model: answers each tx_start with tx_done three cycles later.
  task automatic serve_dump(input int first, input int last);
    int w;
    for (int i = first; i <= last; i++) begin
      w = 0;
      while (tx_start !== 1'b1 && w < 40) begin
        tick();
        w++;
      end
      if (tx_start !== 1'b1) begin
        proto_err++;
        return;
      end
      got[i] = tx_data;
      repeat (3) begin
        tick();
        if (tx_start !== 1'b0 || tx_data !== got[i]) proto_err++;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    n_total++; if (pc_reset_out !== 1'b1) $display("FAIL rst_pc_reset: got %b want 1", pc_reset_out); else n_pass++;
    n_total++; if (pc_enable_out !== 1'b0) $display("FAIL rst_pc_enable: got %b want 0", pc_enable_out); else n_pass++;
    n_total++; if (tx_start !== 1'b0 || tx_data !== 8'h00) $display("FAIL rst_tx: got %b/%h want 0/00", tx_start, tx_data); else n_pass++;
    n_total++; if (running_out !== 1'b0 || halted_out !== 1'b0) $display("FAIL rst_flags: got %b%b want 00", running_out, halted_out); else n_pass++;
    reset_n = 1'b1;
    n_total++; if (pc_reset_out !== 1'b1) $display("FAIL rst_release_hold: got %b want 1", pc_reset_out); else n_pass++;
    tick();
    n_total++; if (pc_reset_out !== 1'b0 || pc_enable_out !== 1'b0) $display("FAIL rst_idle: got rst=%b en=%b want 0/0", pc_reset_out, pc_enable_out); else n_pass++;
    tick();
    n_total++; if (pc_reset_out !== 1'b0 || pc_enable_out !== 1'b0) $display("FAIL rst_idle2: got rst=%b en=%b want 0/0", pc_reset_out, pc_enable_out); else n_pass++;
  endtask

  task automatic test_step_dump();
    set_pipe_a();
    send_cmd(8'h73);
    n_total++; if (pc_enable_out !== 1'b1 || running_out !== 1'b0) $display("FAIL step_enable: got en=%b run=%b want 1/0", pc_enable_out, running_out); else n_pass++;
    tick();
    n_total++; if (pc_enable_out !== 1'b0 || tx_start !== 1'b0) $display("FAIL step_snap: got en=%b txs=%b want 0/0", pc_enable_out, tx_start); else n_pass++;
    tick();
    n_total++; if (tx_start !== 1'b1 || tx_data !== 8'h04) $display("FAIL step_first_tx: got %b/%h want 1/04", tx_start, tx_data); else n_pass++;
    proto_err = 0;
    serve_dump(0, 19);
    n_total++; if (proto_err !== 0) $display("FAIL step_protocol: got %0d errors want 0", proto_err); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n_total++; if (got[i] !== exp_a[i]) $display("FAIL step_byte%0d: got %h want %h", i, got[i], exp_a[i]); else n_pass++;
    end
    tick();
    n_total++; if (tx_start !== 1'b0 || pc_enable_out !== 1'b0) $display("FAIL step_idle: got txs=%b en=%b want 0/0", tx_start, pc_enable_out); else n_pass++;
  endtask

  task automatic test_run_halt();
    int bad;
    pc_instr_in = 32'h0000_0013;
    send_cmd(8'h63);
    n_total++; if (pc_enable_out !== 1'b1 || running_out !== 1'b1) $display("FAIL run_start: got en=%b run=%b want 1/1", pc_enable_out, running_out); else n_pass++;
    repeat (3) tick();
    send_cmd(8'h64);
    n_total++; if (pc_enable_out !== 1'b1 || running_out !== 1'b1) $display("FAIL run_drop_byte: got en=%b run=%b want 1/1", pc_enable_out, running_out); else n_pass++;
    pc_addr_in  = 32'h0000_0040;
    pc_instr_in = 32'hFFFF_FFFF;
    tick();
    n_total++; if (pc_enable_out !== 1'b0 || halted_out !== 1'b1 || running_out !== 1'b0) $display("FAIL halt_detect: got en=%b halt=%b run=%b want 0/1/0", pc_enable_out, halted_out, running_out); else n_pass++;
    tick();
    n_total++; if (tx_start !== 1'b1) $display("FAIL halt_first_tx: got %b want 1", tx_start); else n_pass++;
    pc_instr_in = 32'h0000_0013;
    proto_err = 0;
    serve_dump(0, 19);
    bad = proto_err;
    for (int i = 0; i < 20; i++) if (got[i] !== exp_h[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL halt_dump: got %0d bad bytes/protocol errors want 0", bad); else n_pass++;
    send_cmd(8'h73);
    bad = 0;
    repeat (4) begin
      if (pc_enable_out !== 1'b0 || tx_start !== 1'b0) bad++;
      tick();
    end
    n_total++; if (bad !== 0) $display("FAIL halt_step_ignored: got %0d active cycles want 0", bad); else n_pass++;
    n_total++; if (halted_out !== 1'b1) $display("FAIL halt_sticky: got %b want 1", halted_out); else n_pass++;
  endtask

  task automatic test_reset_cmd();
    send_cmd(8'h72);
    n_total++; if (pc_reset_out !== 1'b1 || pc_enable_out !== 1'b0 || halted_out !== 1'b0) $display("FAIL rcmd_pulse: got rst=%b en=%b halt=%b want 1/0/0", pc_reset_out, pc_enable_out, halted_out); else n_pass++;
    tick();
    n_total++; if (pc_reset_out !== 1'b0) $display("FAIL rcmd_one_cycle: got %b want 0", pc_reset_out); else n_pass++;
    send_cmd(8'h73);
    n_total++; if (pc_enable_out !== 1'b1) $display("FAIL rcmd_step_again: got %b want 1", pc_enable_out); else n_pass++;
    proto_err = 0;
    serve_dump(0, 19);
    n_total++; if (proto_err !== 0) $display("FAIL rcmd_dump: got %0d errors want 0", proto_err); else n_pass++;
  endtask

  task automatic test_dropped_input();
    int bad;
    set_pipe_a();
    send_cmd(8'h64);
    n_total++; if (tx_start !== 1'b0 || pc_enable_out !== 1'b0) $display("FAIL drop_snap: got txs=%b en=%b want 0/0", tx_start, pc_enable_out); else n_pass++;
    tick();
    n_total++; if (tx_start !== 1'b1 || tx_data !== 8'h04) $display("FAIL drop_first_tx: got %b/%h want 1/04", tx_start, tx_data); else n_pass++;
    got[0] = tx_data;
    tick();
    send_cmd(8'h63);
    send_cmd(8'h41);
    n_total++; if (running_out !== 1'b0 || pc_enable_out !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h04) $display("FAIL drop_wait_tx: got run=%b en=%b txs=%b data=%h want 0/0/0/04", running_out, pc_enable_out, tx_start, tx_data); else n_pass++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    proto_err = 0;
    serve_dump(1, 19);
    bad = proto_err;
    for (int i = 0; i < 20; i++) if (got[i] !== exp_a[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL drop_dump: got %0d bad bytes/protocol errors want 0", bad); else n_pass++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    n_total++; if (tx_start !== 1'b0 || running_out !== 1'b0 || pc_enable_out !== 1'b0) $display("FAIL drop_idle: got txs=%b run=%b en=%b want 0/0/0", tx_start, running_out, pc_enable_out); else n_pass++;
    send_cmd(8'h64);
    tick();
    n_total++; if (tx_start !== 1'b1) $display("FAIL redump_start: got %b want 1", tx_start); else n_pass++;
    proto_err = 0;
    serve_dump(0, 19);
    bad = proto_err;
    for (int i = 0; i < 20; i++) if (got[i] !== exp_a[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL redump_bytes: got %0d bad bytes/protocol errors want 0", bad); else n_pass++;
  endtask

  task automatic test_async_reset();
    int stray;
    send_cmd(8'h64);
    proto_err = 0;
    serve_dump(0, 6);
    n_total++; if (proto_err !== 0 || tx_start !== 1'b1 || tx_data !== 8'h20) $display("FAIL async_byte7: got err=%0d txs=%b data=%h want 0/1/20", proto_err, tx_start, tx_data); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (pc_reset_out !== 1'b1 || pc_enable_out !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) $display("FAIL async_dump_rst: got rst=%b en=%b txs=%b data=%h want 1/0/0/00", pc_reset_out, pc_enable_out, tx_start, tx_data); else n_pass++;
    tick();
    tick();
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      tx_done = (c % 4 == 3);
      tick();
      if (tx_start !== 1'b0) stray++;
    end
    tx_done = 1'b0;
    n_total++; if (stray !== 0) $display("FAIL async_no_residual_tx: got %0d tx_start cycles want 0", stray); else n_pass++;
    send_cmd(8'h63);
    n_total++; if (pc_enable_out !== 1'b1) $display("FAIL async_run_start: got %b want 1", pc_enable_out); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (pc_enable_out !== 1'b0 || pc_reset_out !== 1'b1 || running_out !== 1'b0) $display("FAIL async_run_rst: got en=%b rst=%b run=%b want 0/1/0", pc_enable_out, pc_reset_out, running_out); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    n_total++; if (pc_reset_out !== 1'b0 || pc_enable_out !== 1'b0) $display("FAIL async_run_idle: got rst=%b en=%b want 0/0", pc_reset_out, pc_enable_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_step_dump();
    test_run_halt();
    test_reset_cmd();
    test_dropped_input();
    test_async_reset();
    n_total++; if (both_high !== 0) $display("FAIL reset_enable_exclusive: got %0d overlap cycles want 0", both_high); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
